// File: rtl/rev_squarer_pkg.sv
// Shared types and sizing helpers for the bit-serial reversible squarer.
package rev_squarer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sq_state_t;

    // Row counter needs at least one bit even for tiny operands.
    function automatic int row_cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    function automatic int bit_cnt_w(input int w);
        return $clog2(2 * w);
    endfunction

    // Accepting edge to done cycle, inclusive of the done cycle.
    function automatic int SQ_LATENCY(input int w);
        return 2 * w * w + 1;
    endfunction

endpackage

// File: rtl/rev_full_adder.sv
// One-bit reversible full adder built from two cascaded Peres gates.
module rev_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o,
    output logic g1_o,
    output logic g2_o
);

    logic p1_q_out;
    logic p1_r_out;

    // First Peres gate with its third input tied to 0.
    assign p1_q_out = a_i ^ b_i;
    assign p1_r_out = a_i & b_i;

    assign sum_o  = p1_q_out ^ cin_i;
    assign cout_o = p1_r_out ^ (p1_q_out & cin_i);
    assign g1_o   = a_i;
    assign g2_o   = p1_q_out;

endmodule

// File: rtl/rev_squarer_seq.sv
// Bit-serial squarer: shift-and-add over W rows, one result bit per clock,
// time-multiplexing a single reversible full adder.
module rev_squarer_seq
    import rev_squarer_pkg::*;
#(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   sq,
    output sq_state_t        dbg_state
);

    localparam int RW = row_cnt_w(W);
    localparam int BW = bit_cnt_w(W);
    localparam logic [RW-1:0] LAST_ROW = RW'(W - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(2 * W - 1);

    if (W < 2 || W > 16) begin : g_bad_width
        $error("rev_squarer_seq: W must be in 2..16");
    end

    sq_state_t         state_q, state_d;
    logic [W-1:0]      a_q, a_d;
    logic [2*W-1:0]    acc_q, acc_d;
    logic [RW-1:0]     row_q, row_d;
    logic [BW-1:0]     bitp_q, bitp_d;
    logic              carry_q, carry_d;

    logic              accept;
    logic              last_bit;
    logic [2*W-1:0]    pp;
    logic              fa_a, fa_b, fa_sum, fa_cout;
    logic              unused_g1, unused_g2;

    assign accept   = (state_q == IDLE) && start;
    assign last_bit = (bitp_q == LAST_BIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            acc_q   <= '0;
            row_q   <= '0;
            bitp_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            row_q   <= row_d;
            bitp_q  <= bitp_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit && row_q == LAST_ROW) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            IDLE:    ready = 1'b1;
            RUN:     busy  = 1'b1;
            DONE:    done  = 1'b1;
            default: ;
        endcase
    end

    // Partial-product row: the operand shifted into place for the current row.
    assign pp   = {{W{1'b0}}, a_q} << row_q;
    assign fa_a = acc_q[bitp_q];
    assign fa_b = a_q[row_q] & pp[bitp_q];

    rev_full_adder u_fa (
        .a_i    (fa_a),
        .b_i    (fa_b),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout),
        .g1_o   (unused_g1),
        .g2_o   (unused_g2)
    );

    always_comb begin
        a_d     = a_q;
        acc_d   = acc_q;
        row_d   = row_q;
        bitp_d  = bitp_q;
        carry_d = carry_q;
        if (accept) begin
            a_d     = a;
            acc_d   = '0;
            row_d   = '0;
            bitp_d  = '0;
            carry_d = 1'b0;
        end else if (state_q == RUN) begin
            acc_d[bitp_q] = fa_sum;
            if (last_bit) begin
                // Carry out of the top bit is always 0 for a square; drop it.
                bitp_d  = '0;
                row_d   = row_q + 1'b1;
                carry_d = 1'b0;
            end else begin
                bitp_d  = bitp_q + 1'b1;
                carry_d = fa_cout;
            end
        end
    end

    assign sq        = acc_q;
    assign dbg_state = state_q;

    a_row_wrap_carry_zero : assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q == RUN && last_bit) |-> !fa_cout
    );

    a_start_ignored_when_busy : assert property (
        @(posedge clk) disable iff (!rst_n)
        (start && state_q != IDLE) |=> $stable(a_q)
    );

endmodule

// File: tb/tb_rev_squarer_seq.sv
// Directed bench for rev_squarer_seq at W=4 and a full operand sweep at W=8.
module tb_rev_squarer_seq;
    import rev_squarer_pkg::*;

    localparam int LAT4 = 33;
    localparam int LAT8 = 129;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start4, ready4, busy4, done4;
    logic [3:0]  a4;
    logic [7:0]  sq4;
    sq_state_t   st4;
    logic        start8, ready8, busy8, done8;
    logic [7:0]  a8;
    logic [15:0] sq8;
    sq_state_t   st8;

    rev_squarer_seq #(.W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .ready(ready4),
        .busy(busy4), .done(done4), .sq(sq4), .dbg_state(st4)
    );

    rev_squarer_seq #(.W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .ready(ready8),
        .busy(busy8), .done(done8), .sq(sq8), .dbg_state(st8)
    );

    int errors = 0;
    int checks = 0;
    int issued4 = 0, seen4 = 0, issued8 = 0, seen8 = 0;
    logic [7:0]  exp4_q[$];
    int          t4_q[$];
    logic [15:0] exp8_q[$];
    int          t8_q[$];
    logic        chk_ready4 = 1'b0;
    logic        chk_ready8 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive4(input logic [3:0] av, input logic [7:0] ev);
        int t = 0;
        @(negedge clk);
        while (!ready4 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!ready4) begin
            check("ready4_wait_timeout", 32'd0, 32'd1);
            return;
        end
        start4 = 1'b1;
        a4     = av;
        @(posedge clk);
        exp4_q.push_back(ev);
        t4_q.push_back(cyc);
        issued4++;
        @(negedge clk);
        start4 = 1'b0;
        a4     = 4'($urandom_range(0, 15));
    endtask

    task automatic drive8(input logic [7:0] av, input logic [15:0] ev);
        int t = 0;
        @(negedge clk);
        while (!ready8 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!ready8) begin
            check("ready8_wait_timeout", 32'd0, 32'd1);
            return;
        end
        start8 = 1'b1;
        a8     = av;
        @(posedge clk);
        exp8_q.push_back(ev);
        t8_q.push_back(cyc);
        issued8++;
        @(negedge clk);
        start8 = 1'b0;
        a8     = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle4();
        int t = 0;
        while ((exp4_q.size() != 0 || !ready4) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp4_q.size() != 0 || !ready4) check("idle4_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle8();
        int t = 0;
        while ((exp8_q.size() != 0 || !ready8) && t < 600) begin
            @(negedge clk);
            t++;
        end
        if (exp8_q.size() != 0 || !ready8) check("idle8_timeout", 32'd0, 32'd1);
    endtask

    // Monitors: pop the expected result whenever a done pulse appears.
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_ready4) begin
                check("ready4_after_done", 32'(ready4), 32'd1);
                check("done4_one_cycle", 32'(done4), 32'd0);
                chk_ready4 = 1'b0;
            end
            if (done4) begin
                if (exp4_q.size() == 0) begin
                    check("unexpected_done4", 32'd1, 32'd0);
                end else begin
                    check("sq4", 32'(sq4), 32'(exp4_q.pop_front()));
                    check("done4_cycle", 32'(cyc - t4_q.pop_front()), 32'(LAT4));
                    seen4++;
                    chk_ready4 = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_ready8) begin
                check("ready8_after_done", 32'(ready8), 32'd1);
                chk_ready8 = 1'b0;
            end
            if (done8) begin
                if (exp8_q.size() == 0) begin
                    check("unexpected_done8", 32'd1, 32'd0);
                end else begin
                    check("sq8", 32'(sq8), 32'(exp8_q.pop_front()));
                    check("done8_cycle", 32'(cyc - t8_q.pop_front()), 32'(LAT8));
                    seen8++;
                    chk_ready8 = 1'b1;
                end
            end
        end
    end

    initial begin
        start4 = 1'b0; a4 = '0;
        start8 = 1'b0; a8 = '0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready4", 32'(ready4), 32'd1);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_sq4", 32'(sq4), 32'd0);
        check("rst_state4", 32'(st4), 32'(IDLE));
        check("rst_ready8", 32'(ready8), 32'd1);
        check("rst_sq8", 32'(sq8), 32'd0);
        rst_n = 1'b1;

        drive4(4'd0, 8'd0);
        wait_idle4();
        drive4(4'd15, 8'd225);
        wait_idle4();
        for (int i = 0; i < 5; i++) begin
            check("sq4_hold_225", 32'(sq4), 32'd225);
            @(negedge clk);
        end

        drive4(4'd10, 8'd100);
        drive4(4'd1, 8'd1);
        wait_idle4();

        // Second start arrives mid-run and must leave no trace.
        drive4(4'd7, 8'd49);
        repeat (8) @(negedge clk);
        check("busy4_mid_run", 32'(busy4), 32'd1);
        check("state4_mid_run", 32'(st4), 32'(RUN));
        start4 = 1'b1;
        a4     = 4'd3;
        @(negedge clk);
        start4 = 1'b0;
        wait_idle4();
        repeat (40) @(negedge clk);
        check("done4_count_after_ignore", 32'(seen4), 32'(issued4));

        drive4(4'd13, 8'd169);
        repeat (18) @(negedge clk);
        check("busy4_before_reset", 32'(busy4), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy4", 32'(busy4), 32'd0);
        check("midrst_ready4", 32'(ready4), 32'd1);
        check("midrst_done4", 32'(done4), 32'd0);
        check("midrst_sq4", 32'(sq4), 32'd0);
        issued4 -= exp4_q.size();
        exp4_q.delete();
        t4_q.delete();
        chk_ready4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive4(4'd13, 8'd169);
        wait_idle4();

        for (int i = 0; i < 256; i++) begin
            drive8(8'(i), 16'(i * i));
        end
        wait_idle8();
        repeat (3) @(negedge clk);

        check("final_done4_count", 32'(seen4), 32'(issued4));
        check("final_done8_count", 32'(seen8), 32'd256);
        check("final_q4_empty", 32'(exp4_q.size()), 32'd0);
        check("final_q8_empty", 32'(exp8_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
